// File: rtl/bram_program_loader_pkg.sv
// Shared types and sizing for the BRAM program loader.
//   DATA_WIDTH / BYTES_PER_WORD : BRAM word geometry
//   RAM_ADDR_WIDTH / I_BRAM_DEPTH : default write-port address width and depth
//   ld_state_e  : loader FSM encoding (2 bits)
//   pack_word_t : word handed from the byte packer to the FSM
package bram_program_loader_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int RAM_ADDR_WIDTH = 12;
  localparam int I_BRAM_DEPTH   = 4096;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     word;
    logic [BYTES_PER_WORD-1:0] be;
    logic                      last;
  } pack_word_t;

endpackage

// File: rtl/bram_program_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word.
//   clk, rst      : clock, async active-low reset
//   clr_i         : drop any partial word (new load)
//   en_i          : byte handshake this cycle
//   data_i/last_i : stream byte and end-of-image flag
//   word_ready_o  : this handshake completes a word (lane 3 or last)
//   word_o        : merged word/lane mask/last, valid with word_ready_o
module bram_program_loader_byte_packer
  import bram_program_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  output logic       word_ready_o,
  output pack_word_t word_o
);

  logic [1:0]                lane_q, lane_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic [BYTES_PER_WORD-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]     merged_word;
  logic [BYTES_PER_WORD-1:0] merged_be;

  // Current byte merged into the partial word; lanes never written stay 0.
  always_comb begin
    merged_word = word_q;
    merged_be   = be_q;
    if (en_i) begin
      merged_word[{lane_q, 3'b000} +: 8] = data_i;
      merged_be[lane_q]                  = 1'b1;
    end
  end

  assign word_ready_o = en_i & ((lane_q == 2'd3) | last_i);
  assign word_o       = '{word: merged_word, be: merged_be, last: last_i};

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    be_d   = be_q;
    if (clr_i || word_ready_o) begin
      lane_d = '0;
      word_d = '0;
      be_d   = '0;
    end else if (en_i) begin
      lane_d = lane_q + 2'd1;
      word_d = merged_word;
      be_d   = merged_be;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= be_d;
    end
  end

endmodule

// File: rtl/bram_program_loader.sv
// Loads a byte-stream program image into the core's BRAM and holds the core
// stalled until the image is in place.
//   clk, rst                 : clock, async active-low reset
//   start                    : begin a load (only from IDLE/DONE)
//   s_data/s_valid/s_last/s_ready : byte stream, little-endian
//   w_addr/w_dat/w_enb/byte_enb   : BRAM write port
//   cpu_stall                : to core pc_stall
//   busy/done/error          : load status (done/error sticky)
//   word_count/checksum      : words written and their mod-2^32 sum
module bram_program_loader
  import bram_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = I_BRAM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [ADDR_WIDTH-1:0]     w_addr,
  output logic [DATA_WIDTH-1:0]     w_dat,
  output logic                      w_enb,
  output logic [BYTES_PER_WORD-1:0] byte_enb,
  output logic                      cpu_stall,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [ADDR_WIDTH:0]       word_count,
  output logic [DATA_WIDTH-1:0]     checksum
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   MAX_W  = (ADDR_WIDTH+1)'(MAX_WORDS);

  ld_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0]     w_dat_q, w_dat_d;
  logic [BYTES_PER_WORD-1:0] be_q, be_d;
  logic                      last_q, last_d;
  logic [ADDR_WIDTH:0]       wc_q, wc_d;
  logic [DATA_WIDTH-1:0]     cs_q, cs_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      stall_q, stall_d;

  logic       hs;
  logic       start_ok;
  logic       pk_ready;
  pack_word_t pk_word;

  assign s_ready  = (state_q == LD_RECV);
  assign hs       = s_valid & s_ready;
  assign start_ok = start & ((state_q == LD_IDLE) | (state_q == LD_DONE));

  bram_program_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .en_i         (hs),
    .data_i       (s_data),
    .last_i       (s_last),
    .word_ready_o (pk_ready),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d  = state_q;
    w_addr_d = w_addr_q;
    w_dat_d  = w_dat_q;
    be_d     = be_q;
    last_d   = last_q;
    wc_d     = wc_q;
    cs_d     = cs_q;
    done_d   = done_q;
    err_d    = err_q;
    stall_d  = stall_q;
    unique case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          state_d  = LD_RECV;
          w_addr_d = BASE_A;
          wc_d     = '0;
          cs_d     = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          stall_d  = 1'b1;
        end
      end
      LD_RECV: begin
        // Latch the completed word so the write port holds it stable.
        if (pk_ready) begin
          state_d = LD_WRITE;
          w_dat_d = pk_word.word;
          be_d    = pk_word.be;
          last_d  = pk_word.last;
        end
      end
      LD_WRITE: begin
        w_addr_d = w_addr_q + 1'b1;
        wc_d     = wc_q + 1'b1;
        cs_d     = cs_q + w_dat_q;
        if (last_q) begin
          state_d = LD_DONE;
          done_d  = 1'b1;
          stall_d = 1'b0;
        end else if (wc_q + 1'b1 == MAX_W) begin
          // Image did not end within the BRAM window: stop and keep the core parked.
          state_d = LD_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          stall_d = 1'b1;
        end else begin
          state_d = LD_RECV;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LD_IDLE;
      w_addr_q <= '0;
      w_dat_q  <= '0;
      be_q     <= '0;
      last_q   <= 1'b0;
      wc_q     <= '0;
      cs_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr_d;
      w_dat_q  <= w_dat_d;
      be_q     <= be_d;
      last_q   <= last_d;
      wc_q     <= wc_d;
      cs_q     <= cs_d;
      done_q   <= done_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
    end
  end

  assign w_enb      = (state_q == LD_WRITE);
  assign busy       = (state_q == LD_RECV) | (state_q == LD_WRITE);
  assign w_addr     = w_addr_q;
  assign w_dat      = w_dat_q;
  assign byte_enb   = be_q;
  assign cpu_stall  = stall_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_count = wc_q;
  assign checksum   = cs_q;

endmodule

// File: tb/tb_bram_program_loader.sv
// Bench for bram_program_loader: byte driver, BRAM model, write scoreboard.
module tb_bram_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [11:0] w_addr;
  logic [31:0] w_dat;
  logic        w_enb;
  logic [3:0]  byte_enb;
  logic        cpu_stall, busy, done, error;
  logic [12:0] word_count;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  bram_program_loader #(.ADDR_WIDTH(12), .BASE_ADDR('h100), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb), .byte_enb(byte_enb),
    .cpu_stall(cpu_stall), .busy(busy), .done(done), .error(error),
    .word_count(word_count), .checksum(checksum)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [159:0] bytes;   // byte i at [8i+:8]
    int           n;
    bit           lst;     // s_last on final byte
    bit           gap;     // s_valid low one cycle between bytes
    int           mid;     // pulse start before this byte (-1: never)
    int           acc;
    int           wc;
    logic [31:0]  cs;
    bit           err;
    logic [31:0]  m0, m1;
  } vec_t;

  wr_t         exp_q[$];
  logic [31:0] mem [0:4095];
  int          nvec = 0, nerr = 0, wcnt = 0;

  // expected-write model
  logic [31:0] m_word;
  logic [3:0]  m_be;
  int          m_lane, m_widx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_word = '0; m_be = '0; m_lane = 0; m_widx = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit l);
    m_word[8*m_lane +: 8] = b;
    m_be[m_lane] = 1'b1;
    if (m_lane == 3 || l) begin
      exp_q.push_back('{a: 12'(256 + m_widx), d: m_word, be: m_be});
      m_widx++;
      m_word = '0; m_be = '0; m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  // Called at a negedge; returns at a negedge with s_valid low.
  task automatic send_byte(input logic [7:0] b, input bit l, output bit ok);
    ok = 1'b0;
    s_data = b; s_last = l; s_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (s_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // BRAM model + scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst && w_enb) begin
      wcnt++;
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL write: unexpected addr %0h data %0h be %0h", w_addr, w_dat, byte_enb);
      end else begin
        e = exp_q.pop_front();
        chk("write", {16'h0, w_addr, w_dat, byte_enb}, {16'h0, e.a, e.d, e.be});
      end
      for (int i = 0; i < 4; i++)
        if (byte_enb[i]) mem[w_addr][8*i +: 8] = w_dat[8*i +: 8];
    end
  end

  vec_t tv[5];

  task automatic run_vec(input int k);
    int acc;
    bit ok;
    for (int a = 'h100; a < 'h110; a++) mem[a] = '0;
    model_clear();
    wcnt = 0;
    pulse_start();
    chk($sformatf("v%0d start status", k), {busy, s_ready, done, error, cpu_stall}, 5'b11001);
    acc = 0;
    for (int i = 0; i < tv[k].n; i++) begin
      if (i == tv[k].mid) begin
        pulse_start();
        chk($sformatf("v%0d mid start ignored", k), {busy, done, w_addr}, {2'b10, 12'h100 + 12'(i / 4)});
      end
      if (tv[k].gap) @(negedge clk);
      send_byte(tv[k].bytes[8*i +: 8], tv[k].lst && (i == tv[k].n - 1), ok);
      if (!ok) break;
      acc++;
      model_byte(tv[k].bytes[8*i +: 8], tv[k].lst && (i == tv[k].n - 1));
    end
    for (int t = 0; t < 50 && !done; t++) @(negedge clk);
    @(negedge clk);
    chk($sformatf("v%0d done", k), done, 1'b1);
    chk($sformatf("v%0d bytes accepted", k), acc, tv[k].acc);
    chk($sformatf("v%0d word_count", k), word_count, tv[k].wc);
    chk($sformatf("v%0d checksum", k), checksum, tv[k].cs);
    chk($sformatf("v%0d err/stall/busy/ready", k), {error, cpu_stall, busy, s_ready},
        {tv[k].err, tv[k].err, 2'b00});
    chk($sformatf("v%0d mem[base]", k), mem['h100], tv[k].m0);
    chk($sformatf("v%0d mem[base+1]", k), mem['h101], tv[k].m1);
    chk($sformatf("v%0d w_enb pulses", k), wcnt, tv[k].wc);
    chk($sformatf("v%0d pending writes", k), exp_q.size(), 0);
  endtask

  initial begin
    bit ok;
    tv[0] = '{bytes: 160'h0010009300000013, n: 8, lst: 1, gap: 0, mid: -1, acc: 8, wc: 2,
              cs: 32'h001000A6, err: 0, m0: 32'h00000013, m1: 32'h00100093};
    tv[1] = '{bytes: 160'hEEDDCCBBAA, n: 5, lst: 1, gap: 0, mid: -1, acc: 5, wc: 2,
              cs: 32'hDDCCBC98, err: 0, m0: 32'hDDCCBBAA, m1: 32'h000000EE};
    tv[2] = tv[0];
    tv[2].gap = 1;
    tv[3] = '{bytes: 160'h14131211_100F0E0D_0C0B0A09_08070605_04030201, n: 20, lst: 0, gap: 0,
              mid: -1, acc: 16, wc: 4, cs: 32'h2824201C, err: 1,
              m0: 32'h04030201, m1: 32'h08070605};
    tv[4] = tv[1];
    tv[4].mid = 3;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset flags", {cpu_stall, busy, done, error, s_ready, w_enb}, 6'b100000);
    chk("reset port", {w_addr, w_dat, byte_enb}, '0);
    chk("reset counters", {word_count, checksum}, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle stall", {cpu_stall, busy, s_ready}, 3'b100);

    for (int k = 0; k < 5; k++) run_vec(k);

    // reset mid-load after 6 bytes: only the first word reaches BRAM
    for (int a = 'h100; a < 'h110; a++) mem[a] = '0;
    model_clear();
    wcnt = 0;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h11 + i), 1'b0, ok);
      if (ok) model_byte(8'(8'h11 + i), 1'b0);
    end
    rst = 1'b0;
    #1;
    chk("midreset flags", {cpu_stall, busy, done, error, s_ready, w_enb}, 6'b100000);
    chk("midreset port", {w_addr, w_dat, byte_enb}, '0);
    chk("midreset counters", {word_count, checksum}, '0);
    repeat (3) @(negedge clk);
    chk("midreset writes", wcnt, 1);
    chk("midreset mem0", mem['h100], 32'h14131211);
    chk("midreset mem1", mem['h101], 32'h0);
    chk("midreset pending", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
